// File: rtl/proj_pkg.sv
// proj_pkg: shared types and default constants for the perspective projector.
//   coord_t      - one screen/world coordinate (W_DEF bits)
//   bank_entry_t - one per-channel result slot {center_x, center_y, size}
//   *_DEF        - default geometry for the 3D Pong renderer
package proj_pkg;

  localparam int W_DEF          = 10;
  localparam int NUM_CH_DEF     = 4;
  localparam int DEPTH_LOG2_DEF = 7;
  localparam int VP_X_DEF       = 160;
  localparam int VP_Y_DEF       = 120;
  localparam int SIZE_SHIFT_DEF = 3;
  localparam int SCREEN_W_DEF   = 640;
  localparam int SCREEN_H_DEF   = 480;

  typedef logic [W_DEF-1:0] coord_t;

  typedef struct packed {
    coord_t center_x;
    coord_t center_y;
    coord_t size;
  } bank_entry_t;

endpackage

// File: rtl/proj_axis.sv
// proj_axis: one screen axis of the projector (stages S2 and S3).
//   S2 registers k*pos and VP*zc; S3 registers the clamped centre and a
//   clamp flag. All registers hold while en_i is low.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (clears S3 outputs)
//   en_i          pipeline advance
//   k_i, zc_i     depth terms from S1
//   pos_i         world coordinate on this axis from S1
//   center_o      clamped screen coordinate, 0..SCREEN-1
//   clip_o        centre was clamped
module proj_axis #(
  parameter int W          = 10,
  parameter int DEPTH_LOG2 = 7,
  parameter int VP         = 160,
  parameter int SCREEN     = 640
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] k_i,
  input  logic [W-1:0] zc_i,
  input  logic [W-1:0] pos_i,
  output logic [W-1:0] center_o,
  output logic         clip_o
);

  // 2W+3 holds k*pos (< 2^(2W+1)) plus the signed sum without wrap.
  localparam int AW = 2*W + 3;
  localparam logic signed [AW-1:0] VP_S    = AW'(VP);
  localparam logic signed [AW-1:0] SCR_MAX = AW'(SCREEN - 1);

  logic signed [AW-1:0] kx_p1_q;
  logic signed [AW-1:0] vz_p1_q;
  logic signed [AW-1:0] raw_p2_d;
  logic [W-1:0]         center_p2_q;
  logic                 clip_p2_q;

  function automatic logic signed [AW-1:0] ext(input logic [W-1:0] u);
    return $signed({{(AW-W){1'b0}}, u});
  endfunction

  // Returns {clamped, value}.
  function automatic logic [W:0] sat_screen(input logic signed [AW-1:0] v);
    if (v[AW-1])
      return {1'b1, {W{1'b0}}};
    else if (v > SCR_MAX)
      return {1'b1, W'(SCREEN - 1)};
    else
      return {1'b0, v[W-1:0]};
  endfunction

  // ---- S2: products ----
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      kx_p1_q <= ext(k_i) * ext(pos_i);
      vz_p1_q <= VP_S * ext(zc_i);
    end
  end

  always_comb begin
    raw_p2_d = VP_S + (kx_p1_q >>> (DEPTH_LOG2 + 1)) - (vz_p1_q >>> DEPTH_LOG2);
  end

  // ---- S3: sum and clamp ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      center_p2_q <= '0;
      clip_p2_q   <= 1'b0;
    end else if (en_i) begin
      {clip_p2_q, center_p2_q} <= sat_screen(raw_p2_d);
    end
  end

  assign center_o = center_p2_q;
  assign clip_o   = clip_p2_q;

endmodule

// File: rtl/proj_engine.sv
// proj_engine: shared multi-object perspective projector.
//   Projects (ch, x, y, z) world positions toward a vanishing point through a
//   3-stage stallable pipeline and records each delivered result in a
//   per-channel bank readable by channel number.
// Ports:
//   frame_clk, Reset             clock, synchronous active-high reset
//   in_valid/in_ready            input handshake; in_ch, pos_x/y/z payload
//   out_valid/out_ready          output handshake; out_ch, center_x/y, size,
//                                clipped payload
//   rd_ch                        bank read select
//   rd_center_x/y, rd_size       registered bank contents for rd_ch
module proj_engine
  import proj_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int VP_X       = VP_X_DEF,
  parameter int VP_Y       = VP_Y_DEF,
  parameter int SIZE_SHIFT = SIZE_SHIFT_DEF,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [W-1:0]  pos_x,
  input  logic [W-1:0]  pos_y,
  input  logic [W-1:0]  pos_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic [W-1:0]  center_x,
  output logic [W-1:0]  center_y,
  output logic [W-1:0]  size,
  output logic          clipped,
  input  logic [CW-1:0] rd_ch,
  output logic [W-1:0]  rd_center_x,
  output logic [W-1:0]  rd_center_y,
  output logic [W-1:0]  rd_size
);

  localparam logic [W-1:0] D = W'(1 << DEPTH_LOG2);
  localparam bank_entry_t BANK_RST = '{
    center_x: coord_t'(SCREEN_W / 2),
    center_y: coord_t'(SCREEN_H / 2),
    size:     coord_t'(D >> (SIZE_SHIFT + 1))
  };

  logic stall;
  logic adv;

  logic          vld_p0_q, vld_p1_q, vld_p2_q;
  logic [CW-1:0] ch_p0_q, ch_p1_q, ch_p2_q;
  logic [W-1:0]  x_p0_q, y_p0_q, zc_p0_q, k_p0_q;
  logic [W-1:0]  k_p1_q;
  logic [W-1:0]  size_p2_q;
  logic [W-1:0]  zc_p0_d, k_p0_d;
  logic          clip_x, clip_y;

  bank_entry_t bank_q [NUM_CH];
  bank_entry_t rd_q;

  // A full output that is not taken freezes every stage, bubbles included.
  assign stall    = vld_p2_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  always_comb begin
    zc_p0_d = (pos_z > D) ? D : pos_z;
    k_p0_d  = zc_p0_d + D;
  end

  // ---- S1: register inputs, depth clamp ----
  always_ff @(posedge frame_clk) begin
    if (Reset)    vld_p0_q <= 1'b0;
    else if (adv) vld_p0_q <= in_valid;
  end

  always_ff @(posedge frame_clk) begin
    if (adv) begin
      ch_p0_q <= in_ch;
      x_p0_q  <= pos_x;
      y_p0_q  <= pos_y;
      zc_p0_q <= zc_p0_d;
      k_p0_q  <= k_p0_d;
    end
  end

  // ---- S2: products (inside proj_axis), tag and depth carried ----
  always_ff @(posedge frame_clk) begin
    if (Reset)    vld_p1_q <= 1'b0;
    else if (adv) vld_p1_q <= vld_p0_q;
  end

  always_ff @(posedge frame_clk) begin
    if (adv) begin
      ch_p1_q <= ch_p0_q;
      k_p1_q  <= k_p0_q;
    end
  end

  // ---- S3: sums/clamp (inside proj_axis), size, output tag ----
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      vld_p2_q  <= 1'b0;
      ch_p2_q   <= '0;
      size_p2_q <= '0;
    end else if (adv) begin
      vld_p2_q  <= vld_p1_q;
      ch_p2_q   <= ch_p1_q;
      size_p2_q <= k_p1_q >> SIZE_SHIFT;
    end
  end

  proj_axis #(.W(W), .DEPTH_LOG2(DEPTH_LOG2), .VP(VP_X), .SCREEN(SCREEN_W)) u_axis_x (
    .clk_i    (frame_clk),
    .rst_i    (Reset),
    .en_i     (adv),
    .k_i      (k_p0_q),
    .zc_i     (zc_p0_q),
    .pos_i    (x_p0_q),
    .center_o (center_x),
    .clip_o   (clip_x)
  );

  proj_axis #(.W(W), .DEPTH_LOG2(DEPTH_LOG2), .VP(VP_Y), .SCREEN(SCREEN_H)) u_axis_y (
    .clk_i    (frame_clk),
    .rst_i    (Reset),
    .en_i     (adv),
    .k_i      (k_p0_q),
    .zc_i     (zc_p0_q),
    .pos_i    (y_p0_q),
    .center_o (center_y),
    .clip_o   (clip_y)
  );

  assign out_valid = vld_p2_q;
  assign out_ch    = ch_p2_q;
  assign size      = size_p2_q;
  assign clipped   = clip_x | clip_y;

  // ---- Bank: written on output handshake, read registered ----
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CH; i++) bank_q[i] <= BANK_RST;
    end else if (vld_p2_q && out_ready) begin
      bank_q[ch_p2_q] <= '{center_x: center_x, center_y: center_y, size: size_p2_q};
    end
  end

  // Same-cycle write to rd_ch returns the pre-write entry (no bypass).
  always_ff @(posedge frame_clk) begin
    if (Reset) rd_q <= BANK_RST;
    else       rd_q <= bank_q[rd_ch];
  end

  assign rd_center_x = rd_q.center_x;
  assign rd_center_y = rd_q.center_y;
  assign rd_size     = rd_q.size;

endmodule

// File: tb/tb_proj_engine.sv
module tb_proj_engine;

  typedef struct packed {
    logic [1:0] ch;
    logic [9:0] cx;
    logic [9:0] cy;
    logic [9:0] sz;
    logic       clip;
  } exp_t;

  logic       frame_clk;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ch;
  logic [9:0] pos_x, pos_y, pos_z;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;
  logic [9:0] center_x, center_y, size;
  logic       clipped;
  logic [1:0] rd_ch;
  logic [9:0] rd_center_x, rd_center_y, rd_size;

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;
  exp_t exp_q[$];

  logic        hold_pend = 1'b0;
  logic [31:0] held;

  proj_engine dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_z       (pos_z),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .center_x    (center_x),
    .center_y    (center_y),
    .size        (size),
    .clipped     (clipped),
    .rd_ch       (rd_ch),
    .rd_center_x (rd_center_x),
    .rd_center_y (rd_center_y),
    .rd_size     (rd_size)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks that a
  // stalled output holds still.
  always @(negedge frame_clk) begin
    exp_t e;
    if (Reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", {out_ch, center_x, center_y, size}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          chk("out_ch",   32'(out_ch),   32'(e.ch));
          chk("center_x", 32'(center_x), 32'(e.cx));
          chk("center_y", 32'(center_y), 32'(e.cy));
          chk("size",     32'(size),     32'(e.sz));
          chk("clipped",  32'(clipped),  32'(e.clip));
        end
      end
      hold_pend = out_valid && !out_ready;
      held      = {out_ch, center_x, center_y, size};
    end
  end

  task automatic drive(input int ch, input int x, input int y, input int z,
                       input int ecx, input int ecy, input int esz, input int eclip);
    int   g;
    exp_t e;
    g        = 0;
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    pos_x    = 10'(x);
    pos_y    = 10'(y);
    pos_z    = 10'(z);
    @(negedge frame_clk);
    while (!in_ready && g < 50) begin
      @(negedge frame_clk);
      g++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 1);
    end else begin
      e.ch   = 2'(ch);
      e.cx   = 10'(ecx);
      e.cy   = 10'(ecy);
      e.sz   = 10'(esz);
      e.clip = 1'(eclip);
      exp_q.push_back(e);
      n_in++;
    end
    @(posedge frame_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge frame_clk);
      g++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic check_bank(input int ch, input int cx, input int cy, input int sz);
    rd_ch = 2'(ch);
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    chk("bank_cx", 32'(rd_center_x), 32'(cx));
    chk("bank_cy", 32'(rd_center_y), 32'(cy));
    chk("bank_sz", 32'(rd_size),     32'(sz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    pos_x     = '0;
    pos_y     = '0;
    pos_z     = '0;
    out_ready = 1'b1;
    rd_ch     = '0;

    // Reset state
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_center_x",  32'(center_x),  0);
    chk("rst_center_y",  32'(center_y),  0);
    chk("rst_size",      32'(size),      0);
    chk("rst_clipped",   32'(clipped),   0);
    chk("rst_out_ch",    32'(out_ch),    0);
    chk("rst_rd_cx",     32'(rd_center_x), 320);
    chk("rst_rd_cy",     32'(rd_center_y), 240);
    chk("rst_rd_sz",     32'(rd_size),     8);
    #1 Reset = 1'b0;
    @(posedge frame_clk);
    #1;

    // Centre on the far plane, with latency
    drive(1, 320, 240, 0, 320, 240, 16, 0);
    @(negedge frame_clk); chk("latency_t1", 32'(out_valid), 0);
    @(negedge frame_clk); chk("latency_t2", 32'(out_valid), 0);
    @(negedge frame_clk); chk("latency_t3", 32'(out_valid), 1);
    wait_empty();
    check_bank(1, 320, 240, 16);

    // Corners, depth saturation, clamps, interior point; back to back
    @(posedge frame_clk);
    #1;
    drive(0, 0,    0,    128, 0,   0,   32, 0);
    drive(2, 639,  479,  128, 639, 479, 32, 0);
    drive(3, 320,  240,  200, 320, 240, 32, 0);
    drive(0, 1023, 240,  128, 639, 240, 32, 1);
    drive(1, 100,  50,   64,  155, 97,  24, 0);
    drive(2, 0,    1023, 0,   160, 479, 16, 1);
    wait_empty();
    check_bank(1, 155, 97, 24);

    // Backpressure: 5 items while out_ready drops for 3 cycles
    @(posedge frame_clk);
    #1;
    n_in  = 0;
    n_out = 0;
    fork
      begin
        drive(0, 10, 20,  128, 10, 20,  32, 0);
        drive(1, 30, 40,  128, 30, 40,  32, 0);
        drive(2, 50, 60,  128, 50, 60,  32, 0);
        drive(3, 70, 80,  128, 70, 80,  32, 0);
        drive(0, 90, 100, 128, 90, 100, 32, 0);
      end
      begin
        repeat (3) @(posedge frame_clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge frame_clk);
          if (out_valid) chk("in_ready_stall", 32'(in_ready), 0);
        end
        @(posedge frame_clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_empty();
    chk("bp_count_out", 32'(n_out), 5);
    chk("bp_count_in",  32'(n_in),  5);
    check_bank(0, 90, 100, 32);
    check_bank(3, 70, 80,  32);

    // Read during write on channel 2
    @(posedge frame_clk);
    #1;
    out_ready = 1'b0;
    rd_ch     = 2'd2;
    drive(2, 200, 150, 128, 200, 150, 32, 0);
    repeat (3) @(posedge frame_clk);
    #1 out_ready = 1'b1;
    @(posedge frame_clk);
    @(negedge frame_clk);
    chk("rdw_old_cx", 32'(rd_center_x), 50);
    chk("rdw_old_cy", 32'(rd_center_y), 60);
    @(negedge frame_clk);
    chk("rdw_new_cx", 32'(rd_center_x), 200);
    chk("rdw_new_cy", 32'(rd_center_y), 150);
    chk("rdw_new_sz", 32'(rd_size),     32);
    wait_empty();

    // Reset mid-stall with 3 items in flight
    @(posedge frame_clk);
    #1;
    out_ready = 1'b0;
    drive(0, 5,  6,  128, 5,  6,  32, 0);
    drive(1, 7,  8,  128, 7,  8,  32, 0);
    drive(2, 11, 12, 128, 11, 12, 32, 0);
    repeat (2) @(posedge frame_clk);
    #1;
    Reset = 1'b1;
    exp_q.delete();
    @(posedge frame_clk);
    @(negedge frame_clk);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready",  32'(in_ready),  1);
    chk("mid_rst_center_x",  32'(center_x),  0);
    chk("mid_rst_size",      32'(size),      0);
    #1;
    Reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c);
      @(posedge frame_clk);
      @(negedge frame_clk);
      chk("rst_bank_cx", 32'(rd_center_x), 320);
      chk("rst_bank_cy", 32'(rd_center_y), 240);
      chk("rst_bank_sz", 32'(rd_size),     8);
    end
    repeat (4) begin
      @(negedge frame_clk);
      chk("flushed_out_valid", 32'(out_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
